// File: rtl/serial_mod_pkg.sv
// Shared types and modular-add helper for the serial remainder unit.
package serial_mod_pkg;

    localparam int unsigned LEN_W = 16;

    typedef enum logic {IDLE, ACC} state_e;

    // Operands are already reduced (< m <= 255), so a single subtract suffices.
    function automatic logic [8:0] mod_add(input logic [8:0] a, input logic [8:0] b,
                                           input logic [8:0] m);
        logic [8:0] s;
        s = a + b;
        if (s >= m) begin
            s = s - m;
        end
        return s;
    endfunction

endpackage

// File: rtl/mod_bit_step.sv
// Combinational single-bit update of the running remainder (and LSB-first weight).
module mod_bit_step
    import serial_mod_pkg::*;
#(
    parameter int unsigned MOD       = 3,
    parameter bit          LSB_FIRST = 1'b0,
    localparam int unsigned RW       = $clog2(MOD)
) (
    input  logic [RW-1:0] acc,
    input  logic [RW-1:0] wgt,
    input  logic          b,
    output logic [RW-1:0] acc_nxt,
    output logic [RW-1:0] wgt_nxt
);

    localparam logic [8:0] M = 9'(MOD);

    logic [8:0] a9;
    logic [8:0] w9;

    assign a9 = 9'(acc);
    assign w9 = 9'(wgt);

    if (LSB_FIRST) begin : g_lsb
        assign acc_nxt = RW'(mod_add(a9, b ? w9 : 9'd0, M));
        assign wgt_nxt = RW'(mod_add(w9, w9, M));
    end else begin : g_msb
        // 2*acc + b expressed as acc + (acc + b); the sum stays below 2*MOD.
        assign acc_nxt = RW'(mod_add(a9, a9 + 9'(b), M));
        assign wgt_nxt = wgt;
    end

endmodule

// File: rtl/serial_mod_n.sv
// Framed serial stream remainder: frame value mod MOD, DW bits per beat, one-deep result register.
module serial_mod_n
    import serial_mod_pkg::*;
#(
    parameter int unsigned MOD       = 3,
    parameter int unsigned DW        = 1,
    parameter bit          LSB_FIRST = 1'b0,
    localparam int unsigned RW       = $clog2(MOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_rem,
    output logic             out_zero,
    output logic [LEN_W-1:0] out_len,
    output logic             busy
);

    localparam logic [LEN_W:0] DW_EXT = (LEN_W + 1)'(DW);

    state_e             state_q, state_d;
    logic [RW-1:0]      acc_q, acc_d, wgt_q, wgt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               out_valid_q, out_valid_d, out_zero_q, out_zero_d;
    logic [RW-1:0]      out_rem_q, out_rem_d;
    logic [LEN_W-1:0]   out_len_q, out_len_d;

    logic               accept, start;
    logic [RW-1:0]      acc_base, wgt_base, acc_beat, wgt_beat;
    logic [LEN_W-1:0]   len_base, len_new;
    logic [LEN_W:0]     len_sum;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // A beat arriving with no frame open counts as an implicit first beat.
    assign start    = in_first || (state_q == IDLE);
    assign acc_base = start ? '0 : acc_q;
    assign wgt_base = start ? RW'(1) : wgt_q;
    assign len_base = start ? '0 : len_q;
    assign len_sum  = {1'b0, len_base} + DW_EXT;
    assign len_new  = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

    for (genvar gi = 0; gi < DW; gi++) begin : g_step
        localparam int unsigned BI = LSB_FIRST ? gi : DW - 1 - gi;
        logic [RW-1:0] acc_in, wgt_in, acc_o, wgt_o;
        if (gi == 0) begin : g_head
            assign acc_in = acc_base;
            assign wgt_in = wgt_base;
        end else begin : g_link
            assign acc_in = g_step[gi-1].acc_o;
            assign wgt_in = g_step[gi-1].wgt_o;
        end
        mod_bit_step #(
            .MOD       (MOD),
            .LSB_FIRST (LSB_FIRST)
        ) u_step (
            .acc     (acc_in),
            .wgt     (wgt_in),
            .b       (in_data[BI]),
            .acc_nxt (acc_o),
            .wgt_nxt (wgt_o)
        );
    end

    assign acc_beat = g_step[DW-1].acc_o;
    assign wgt_beat = g_step[DW-1].wgt_o;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        wgt_d       = wgt_q;
        len_d       = len_q;
        out_valid_d = out_valid_q && !out_ready;
        out_rem_d   = out_rem_q;
        out_zero_d  = out_zero_q;
        out_len_d   = out_len_q;
        if (accept) begin
            if (in_last) begin
                state_d     = IDLE;
                acc_d       = '0;
                wgt_d       = RW'(1);
                len_d       = '0;
                out_valid_d = 1'b1;
                out_rem_d   = acc_beat;
                out_zero_d  = (acc_beat == '0);
                out_len_d   = len_new;
            end else begin
                state_d = ACC;
                acc_d   = acc_beat;
                wgt_d   = wgt_beat;
                len_d   = len_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            wgt_q       <= RW'(1);
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_rem_q   <= '0;
            out_zero_q  <= 1'b0;
            out_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            wgt_q       <= wgt_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_rem_q   <= out_rem_d;
            out_zero_q  <= out_zero_d;
            out_len_q   <= out_len_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_rem   = out_rem_q;
    assign out_zero  = out_zero_q;
    assign out_len   = out_len_q;
    assign busy      = (state_q == ACC);

endmodule

// File: tb/tb_serial_mod_n.sv
// Directed bench: three configurations (mod3 MSB, mod5 DW4 MSB, mod7 LSB) sharing clock and reset.
module tb_serial_mod_n;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv3, ir3, d3, f3, l3, ov3, or3, z3, b3;
    logic [1:0]  r3;
    logic [15:0] n3;
    logic        iv5, ir5, f5, l5, ov5, or5, z5, b5;
    logic [3:0]  d5;
    logic [2:0]  r5;
    logic [15:0] n5;
    logic        iv7, ir7, d7, f7, l7, ov7, or7, z7, b7;
    logic [2:0]  r7;
    logic [15:0] n7;

    serial_mod_n #(.MOD(3), .DW(1), .LSB_FIRST(1'b0)) u_m3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_data(d3), .in_first(f3),
        .in_last(l3), .out_valid(ov3), .out_ready(or3), .out_rem(r3), .out_zero(z3),
        .out_len(n3), .busy(b3));
    serial_mod_n #(.MOD(5), .DW(4), .LSB_FIRST(1'b0)) u_m5 (
        .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .in_data(d5), .in_first(f5),
        .in_last(l5), .out_valid(ov5), .out_ready(or5), .out_rem(r5), .out_zero(z5),
        .out_len(n5), .busy(b5));
    serial_mod_n #(.MOD(7), .DW(1), .LSB_FIRST(1'b1)) u_m7 (
        .clk(clk), .rst(rst), .in_valid(iv7), .in_ready(ir7), .in_data(d7), .in_first(f7),
        .in_last(l7), .out_valid(ov7), .out_ready(or7), .out_rem(r7), .out_zero(z7),
        .out_len(n7), .busy(b7));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one beat on DUT sel (0:mod3, 1:mod5, 2:mod7); returns #1 after the accepting edge.
    task automatic beat(input int sel, input logic [3:0] d, input logic f, input logic l);
        logic rdy;
        int   n;
        n = 0;
        case (sel)
            0: begin iv3 = 1'b1; d3 = d[0]; f3 = f; l3 = l; end
            1: begin iv5 = 1'b1; d5 = d;    f5 = f; l5 = l; end
            default: begin iv7 = 1'b1; d7 = d[0]; f7 = f; l7 = l; end
        endcase
        forever begin
            rdy = (sel == 0) ? ir3 : (sel == 1) ? ir5 : ir7;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 20) begin
                check("beat_timeout", 32'd0, 32'd1);
                break;
            end
        end
        #1;
        iv3 = 1'b0; iv5 = 1'b0; iv7 = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        {iv3, d3, f3, l3} = '0;
        {iv5, d5, f5, l5} = '0;
        {iv7, d7, f7, l7} = '0;
        or3 = 1'b1; or5 = 1'b1; or7 = 1'b1;
        #12;
        check("rst_out_valid", 32'(ov3), 32'd0);
        check("rst_busy", 32'(b3), 32'd0);
        check("rst_out_len", 32'(n3), 32'd0);
        check("rst_out_rem", 32'(r3), 32'd0);
        check("rst_out_zero", 32'(z3), 32'd0);
        check("rst_in_ready", 32'(ir3), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Mod 3 MSB: 1011 = 11 -> 2, then back-to-back 110 = 6 -> 0.
        beat(0, 4'd1, 1'b1, 1'b0);
        check("t1_busy", 32'(b3), 32'd1);
        beat(0, 4'd0, 1'b0, 1'b0);
        beat(0, 4'd1, 1'b0, 1'b0);
        beat(0, 4'd1, 1'b0, 1'b1);
        check("t1_valid", 32'(ov3), 32'd1);
        check("t1_rem", 32'(r3), 32'd2);
        check("t1_zero", 32'(z3), 32'd0);
        check("t1_len", 32'(n3), 32'd4);
        check("t2_ready0", 32'(ir3), 32'd1);
        beat(0, 4'd1, 1'b1, 1'b0);
        check("t2_ready1", 32'(ir3), 32'd1);
        beat(0, 4'd1, 1'b0, 1'b0);
        check("t2_ready2", 32'(ir3), 32'd1);
        beat(0, 4'd0, 1'b0, 1'b1);
        check("t2_valid", 32'(ov3), 32'd1);
        check("t2_rem", 32'(r3), 32'd0);
        check("t2_zero", 32'(z3), 32'd1);
        check("t2_len", 32'(n3), 32'd3);
        @(posedge clk); #1;
        check("t2_drain", 32'(ov3), 32'd0);

        // Mod 5, 4 bits/beat MSB: F3 = 243 -> 3; single beat 5 -> 0.
        beat(1, 4'hF, 1'b1, 1'b0);
        beat(1, 4'h3, 1'b0, 1'b1);
        check("t3_rem", 32'(r5), 32'd3);
        check("t3_zero", 32'(z5), 32'd0);
        check("t3_len", 32'(n5), 32'd8);
        beat(1, 4'h5, 1'b1, 1'b1);
        check("t3b_rem", 32'(r5), 32'd0);
        check("t3b_zero", 32'(z5), 32'd1);
        check("t3b_len", 32'(n5), 32'd4);

        // Mod 7 LSB-first: 1,0,1,1 = 13 -> 6; 1,1,1 = 7 -> 0.
        beat(2, 4'd1, 1'b1, 1'b0);
        beat(2, 4'd0, 1'b0, 1'b0);
        beat(2, 4'd1, 1'b0, 1'b0);
        beat(2, 4'd1, 1'b0, 1'b1);
        check("t4_rem", 32'(r7), 32'd6);
        check("t4_len", 32'(n7), 32'd4);
        beat(2, 4'd1, 1'b1, 1'b0);
        beat(2, 4'd1, 1'b0, 1'b0);
        beat(2, 4'd1, 1'b0, 1'b1);
        check("t4b_rem", 32'(r7), 32'd0);
        check("t4b_zero", 32'(z7), 32'd1);

        // Backpressure on mod 3: frame 10 = 2 held while single-beat frame 1 waits.
        or3 = 1'b0;
        beat(0, 4'd1, 1'b1, 1'b0);
        beat(0, 4'd0, 1'b0, 1'b1);
        iv3 = 1'b1; d3 = 1'b1; f3 = 1'b1; l3 = 1'b1;
        #1;
        check("t5_ready_blocked", 32'(ir3), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("t5_hold_valid", 32'(ov3), 32'd1);
        check("t5_hold_rem", 32'(r3), 32'd2);
        check("t5_hold_len", 32'(n3), 32'd2);
        check("t5_hold_busy", 32'(b3), 32'd0);
        or3 = 1'b1;
        @(posedge clk); #1;
        iv3 = 1'b0;
        check("t5_new_valid", 32'(ov3), 32'd1);
        check("t5_new_rem", 32'(r3), 32'd1);
        check("t5_new_len", 32'(n3), 32'd1);
        @(posedge clk); #1;
        check("t5_drain", 32'(ov3), 32'd0);

        // Abort on mod 7: 1,1 dropped by a new first; restarted frame 0,1 LSB = 2.
        beat(2, 4'd1, 1'b1, 1'b0);
        beat(2, 4'd1, 1'b0, 1'b0);
        beat(2, 4'd0, 1'b1, 1'b0);
        check("t6_no_result", 32'(ov7), 32'd0);
        check("t6_busy", 32'(b7), 32'd1);
        beat(2, 4'd1, 1'b0, 1'b1);
        check("t6_rem", 32'(r7), 32'd2);
        check("t6_len", 32'(n7), 32'd2);

        // Async reset with a pending mod-5 result and an open mod-7 frame.
        or5 = 1'b0;
        beat(1, 4'h2, 1'b1, 1'b1);
        check("t6_pend_valid", 32'(ov5), 32'd1);
        beat(2, 4'd1, 1'b1, 1'b0);
        check("t6_open_busy", 32'(b7), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_valid", 32'(ov5), 32'd0);
        check("t6_rst_len", 32'(n5), 32'd0);
        check("t6_rst_busy", 32'(b7), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        or5 = 1'b1;
        // Beat without first in idle starts a frame implicitly.
        beat(2, 4'd1, 1'b0, 1'b1);
        check("t6_implicit_rem", 32'(r7), 32'd1);
        check("t6_implicit_len", 32'(n7), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
